spi_frame_loader: RTL and testbench

Upstream producer for the LED channel memory that strip_driver reads. It receives a host frame over a mode-0 SPI slave link and writes channel bytes (G,R,B per LED, as strip_driver expects) into the shared byte memory through a single write port. It replaces the on-chip debug counter as the memory writer in the 50 MHz domain. It is receive-only; there is no MISO.

---
 rtl/spi_frame_loader.sv | 131 +++++++++++++
 tb/tb_spi_frame_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that writes a host frame ({ADDR_HI, ADDR_LO, data...}) into the LED channel memory.
// Write strobe lands 3 clk cycles after the 8th SCK rise at the pin; no backpressure, receive-only.
module spi_frame_loader #(
  parameter int NUM_CHANNELS = 216,
  parameter int BASE_ADDRESS = 0,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH:0]   NUM_C   = (ADDR_WIDTH+1)'(NUM_CHANNELS);
  localparam logic [ADDR_WIDTH:0]   OFF_MAX = '1;

  state_t                state_q;
  logic                  sck_s1_q, sck_s2_q, sck_prev_q;
  logic                  mosi_s1_q, mosi_s2_q;
  logic                  cs_s1_q, cs_s2_q, cs_prev_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            hdr_hi_q;
  logic [ADDR_WIDTH:0]   offset_q;
  logic [1:0]            settle_q;
  logic                  armed_q;

  logic                  sck_rise, cs_fall, cs_rise;
  logic [7:0]            byte_d;
  logic [ADDR_WIDTH-1:0] start_d;

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s2_q;
  assign cs_rise  = ~cs_prev_q & cs_s2_q;
  assign byte_d   = {shift_q[6:0], mosi_s2_q};
  assign start_d  = ADDR_WIDTH'({hdr_hi_q, byte_d});
  assign busy     = (state_q != IDLE) && !cs_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hdr_hi_q    <= '0;
      offset_q    <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sck_s1_q    <= spi_sck;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      mosi_s1_q   <= spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
      cs_s1_q     <= spi_cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      mem_we      <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      // The preset chain cannot tell us CS was really high, so a frame already in
      // flight at reset release is skipped until the real pin level reads high.
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      else if (cs_s2_q)     armed_q  <= 1'b1;

      if (state_q == IDLE) begin
        if (cs_fall && armed_q) begin
          overflow  <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= HDR_HI;
        end
      end else if (cs_rise) begin
        state_q <= IDLE;
        if (state_q == DATA && bit_cnt_q == 3'd0) frame_done  <= 1'b1;
        else                                      frame_error <= 1'b1;
      end else if (sck_rise && !cs_s2_q) begin
        shift_q   <= byte_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            HDR_HI: begin
              hdr_hi_q <= byte_d;
              state_q  <= HDR_LO;
            end
            HDR_LO: begin
              offset_q <= {1'b0, start_d};
              state_q  <= DATA;
            end
            DATA: begin
              if (offset_q < NUM_C) begin
                mem_we    <= 1'b1;
                mem_waddr <= BASE_A + offset_q[ADDR_WIDTH-1:0];
                mem_wdata <= byte_d;
              end else begin
                overflow  <= 1'b1;
              end
              if (offset_q != OFF_MAX) offset_q <= offset_q + 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench: drivers push expected writes/pulses, a negedge monitor pops and compares.
module tb_spi_frame_loader;
  localparam int NCH = 216;
  localparam int AW  = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_sck = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          frame_done, frame_error, overflow, busy;

  spi_frame_loader #(.NUM_CHANNELS(NCH), .BASE_ADDRESS(0), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .frame_done(frame_done), .frame_error(frame_error), .overflow(overflow), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_cyc_q[$];
  int exp_pulse_q[$];   // 1 = frame_done, 2 = frame_error
  logic [7:0] fr_q[$];
  int last_rise = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_addr_q.size() == 0) check("unexpected_write_addr", int'(mem_waddr), -1);
        else begin
          check("write_addr", int'(mem_waddr), exp_addr_q.pop_front());
          check("write_data", int'(mem_wdata), exp_data_q.pop_front());
          check("write_latency_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (frame_done || frame_error) begin
        if (exp_pulse_q.size() == 0) check("unexpected_pulse", frame_done ? 1 : 2, 0);
        else check("pulse_kind", (frame_done && frame_error) ? 3 : (frame_done ? 1 : 2),
                   exp_pulse_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    tick(3);
    spi_sck = 1'b1;
    last_rise = cyc;
    tick(3);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_we, input int addr);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (exp_we) begin
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(int'(b));
      exp_cyc_q.push_back(last_rise + 3);
    end
  endtask

  // Frame-level reference: a write for every data byte whose offset is inside the channel range.
  task automatic run_frame(input int extra_bits, input int gap);
    int  n;
    int  start;
    int  off;
    bit  ovf;
    n = fr_q.size();
    start = 0;
    ovf = 0;
    if (n >= 2) start = ((int'(fr_q[0]) << 8) | int'(fr_q[1])) & ((1 << AW) - 1);
    spi_cs_n = 1'b0;
    tick(4);
    check("busy_in_frame", int'(busy), 1);
    check("overflow_clear_at_cs_fall", int'(overflow), 0);
    for (int i = 0; i < n; i++) begin
      if (i < 2) send_byte(fr_q[i], 1'b0, 0);
      else begin
        off = start + i - 2;
        if (off < NCH) send_byte(fr_q[i], 1'b1, off);
        else begin
          ovf = 1;
          send_byte(fr_q[i], 1'b0, 0);
        end
      end
    end
    for (int i = 0; i < extra_bits; i++) send_bit(1'($urandom_range(0, 1)));
    tick(3);
    exp_pulse_q.push_back((n >= 2 && extra_bits == 0) ? 1 : 2);
    spi_cs_n = 1'b1;
    tick(gap);
    check("overflow_after_frame", int'(overflow), int'(ovf));
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hw;
    int n, extra;
    tick(3);
    check("reset_mem_we", int'(mem_we), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_waddr", int'(mem_waddr), 0);
    rst = 1'b0;
    tick(6);

    fr_q = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    run_frame(0, 6);
    fr_q = '{8'h00, 8'hD6, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(0, 6);
    fr_q = '{8'h00};
    run_frame(0, 6);
    fr_q = '{8'h00, 8'h05, 8'h77};
    run_frame(4, 6);

    // Reset in the middle of a data byte with CS held low.
    spi_cs_n = 1'b0;
    tick(4);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h44, 1'b1, 3);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(3);
    rst = 1'b1;
    tick(2);
    check("midreset_mem_we", int'(mem_we), 0);
    check("midreset_waddr", int'(mem_waddr), 0);
    check("midreset_wdata", int'(mem_wdata), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_pulses", int'(frame_done | frame_error), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_byte(8'hEE, 1'b0, 0);
    send_byte(8'h12, 1'b0, 0);
    tick(3);
    check("postreset_busy_cs_low", int'(busy), 0);
    check("postreset_overflow", int'(overflow), 0);
    spi_cs_n = 1'b1;
    tick(8);
    fr_q = '{8'h00, 8'h00, 8'h5A};
    run_frame(0, 6);

    // Back-to-back: overflowing frame then header-only frame after a 3-cycle CS gap.
    fr_q = '{8'h00, 8'hD6, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(0, 3);
    fr_q = '{8'h00, 8'h10};
    run_frame(0, 6);

    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 7);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      hw = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) hw[12:0] = 13'(200 + $urandom_range(0, 20));
      fr_q.delete();
      if (n > 0) fr_q.push_back(hw[15:8]);
      if (n > 1) fr_q.push_back(hw[7:0]);
      for (int k = 2; k < n; k++) fr_q.push_back(8'($urandom_range(0, 255)));
      run_frame(extra, $urandom_range(3, 8));
    end

    tick(10);
    check("writes_left_pending", exp_addr_q.size(), 0);
    check("pulses_left_pending", exp_pulse_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
